// File: rtl/cam_pixel_packer.sv
// OV7670-style byte stream capture, pixel assembly/expansion and FWFT pixel FIFO.
// Optional macro CAM_REPLICATE_LSB_EN: channel expansion replicates MSBs into the LSBs.
module cam_pixel_packer #(
  parameter int DATA_W     = 8,
  parameter int CH_W       = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LINE_W     = 640,
  parameter int FRAME_H    = 480,
  localparam int XW        = $clog2(LINE_W + 1),
  localparam int YW        = $clog2(FRAME_H + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [1:0]        fmt,
  input  logic              cam_href,
  input  logic              cam_vsync,
  input  logic [DATA_W-1:0] cam_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_r,
  output logic [CH_W-1:0]   out_g,
  output logic [CH_W-1:0]   out_b,
  output logic              out_sof,
  output logic              out_eol,
  output logic [XW-1:0]     x_count,
  output logic [YW-1:0]     y_count,
  output logic [15:0]       frame_count,
  output logic              overflow,
  output logic              line_err,
  input  logic              clr_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 3 * CH_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_ACTIVE  = 2'd2
  } state_t;

  state_t              state_r, state_nxt_s;
  logic                enter_active_s, frame_end_s;
  logic                cap_s, pix_done_s, line_end_s, lerr_set_s;
  logic                vs_seen_r, href_d_r, phase_r, sof_pend_r;
  logic [1:0]          fmt_r;
  logic [DATA_W-1:0]   hi_r;
  logic [XW-1:0]       x_r;
  logic [YW-1:0]       y_r;
  logic [15:0]         frame_r;
  logic [CH_W-1:0]     r_s, g_s, b_s;
  logic                pix_vld_r;
  logic [EW-1:0]       pix_r;
  logic [EW-1:0]       mem_r [FIFO_DEPTH];
  logic [AW:0]         wr_ptr_r, rd_ptr_r, count_s;
  logic                full_s, push_s, pop_s, wr_en_s, drop_s, head_vld_s;
  logic                ovf_r, lerr_r;

  // Widen an n-bit channel to CH_W bits, MSB-aligned.
  function automatic logic [CH_W-1:0] expand(input logic [15:0] v, input int n);
    logic [CH_W+15:0] t;
    logic [CH_W+15:0] acc;
    t = {v, {CH_W{1'b0}}} << (16 - n);
`ifdef CAM_REPLICATE_LSB_EN
    acc = '0;
    for (int k = 0; k < CH_W; k++) begin
      if (k * n < CH_W) acc = acc | (t >> (k * n));
      else acc = acc;
    end
`else
    acc = t;
`endif
    return acc[CH_W+15 -: CH_W];
  endfunction

  always_comb begin
    state_nxt_s    = state_r;
    enter_active_s = 1'b0;
    frame_end_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable) state_nxt_s = ST_WAIT_VS;
        else state_nxt_s = ST_IDLE;
      end
      ST_WAIT_VS: begin
        if (!enable) begin
          state_nxt_s = ST_IDLE;
        end else if (vs_seen_r && !cam_vsync) begin
          state_nxt_s    = ST_ACTIVE;
          enter_active_s = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT_VS;
        end
      end
      ST_ACTIVE: begin
        if (!enable) begin
          state_nxt_s = ST_IDLE;
        end else if (cam_vsync) begin
          state_nxt_s = ST_WAIT_VS;
          frame_end_s = 1'b1;
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  assign cap_s      = (state_r == ST_ACTIVE) && (state_nxt_s == ST_ACTIVE);
  assign pix_done_s = cap_s && cam_href && phase_r;
  assign line_end_s = cap_s && !cam_href && href_d_r && (x_r != '0);
  assign lerr_set_s = line_end_s && (x_r != XW'(LINE_W));

  always_comb begin
    r_s = '0;
    g_s = '0;
    b_s = '0;
    case (fmt_r)
      2'd1: begin
        r_s = expand(16'(hi_r[6:2]), 5);
        g_s = expand(16'({hi_r[1:0], cam_data[7:5]}), 5);
        b_s = expand(16'(cam_data[4:0]), 5);
      end
      2'd2: begin
        r_s = expand(16'(hi_r), DATA_W);
        g_s = expand(16'(hi_r), DATA_W);
        b_s = expand(16'(hi_r), DATA_W);
      end
      default: begin
        r_s = expand(16'(hi_r[7:3]), 5);
        g_s = expand(16'({hi_r[2:0], cam_data[7:5]}), 6);
        b_s = expand(16'(cam_data[4:0]), 5);
      end
    endcase
  end

  // vs_seen_r remembers a vsync-high level while waiting, so ACTIVE starts on its fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      vs_seen_r  <= 1'b0;
      href_d_r   <= 1'b0;
      phase_r    <= 1'b0;
      sof_pend_r <= 1'b0;
      fmt_r      <= 2'd0;
      hi_r       <= '0;
      x_r        <= '0;
      y_r        <= '0;
      frame_r    <= 16'd0;
    end else begin
      state_r   <= state_nxt_s;
      href_d_r  <= cam_href;
      vs_seen_r <= (state_nxt_s == ST_WAIT_VS) &&
                   (((state_r == ST_WAIT_VS) && vs_seen_r) || cam_vsync);
      if (cap_s && cam_href) phase_r <= !phase_r;
      else phase_r <= 1'b0;
      if (cap_s && cam_href && !phase_r) hi_r <= cam_data;
      if (enter_active_s) begin
        fmt_r      <= fmt;
        sof_pend_r <= 1'b1;
      end else if (pix_done_s) begin
        sof_pend_r <= 1'b0;
      end
      if (enter_active_s || (state_nxt_s != ST_ACTIVE) || line_end_s) x_r <= '0;
      else if (pix_done_s && (x_r != XW'(LINE_W))) x_r <= x_r + 1'b1;
      if (enter_active_s) y_r <= '0;
      else if (line_end_s && (y_r != YW'(FRAME_H))) y_r <= y_r + 1'b1;
      if (frame_end_s) frame_r <= frame_r + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_vld_r <= 1'b0;
      pix_r     <= '0;
    end else begin
      pix_vld_r <= pix_done_s;
      if (pix_done_s) pix_r <= {sof_pend_r, (x_r == XW'(LINE_W - 1)), r_s, g_s, b_s};
    end
  end

  // Full is the pre-edge occupancy, so a simultaneous pop makes room for the push.
  assign count_s = wr_ptr_r - rd_ptr_r;
  assign full_s  = (count_s == (AW + 1)'(FIFO_DEPTH));
  assign push_s  = pix_vld_r;
  assign pop_s   = head_vld_s && out_ready;
  assign wr_en_s = push_s && (!full_s || pop_s);
  assign drop_s  = push_s && full_s && !pop_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_s) rd_ptr_r <= rd_ptr_r + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_s) mem_r[wr_ptr_r[AW-1:0]] <= pix_r;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_r  <= 1'b0;
      lerr_r <= 1'b0;
    end else begin
      if (drop_s) ovf_r <= 1'b1;
      else if (clr_err) ovf_r <= 1'b0;
      if (lerr_set_s) lerr_r <= 1'b1;
      else if (clr_err) lerr_r <= 1'b0;
    end
  end

  assign head_vld_s = (count_s != '0);

  always_comb begin
    out_valid = head_vld_s;
    if (head_vld_s) {out_sof, out_eol, out_r, out_g, out_b} = mem_r[rd_ptr_r[AW-1:0]];
    else {out_sof, out_eol, out_r, out_g, out_b} = '0;
  end

  assign x_count     = x_r;
  assign y_count     = y_r;
  assign frame_count = frame_r;
  assign overflow    = ovf_r;
  assign line_err    = lerr_r;

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Scoreboard bench for cam_pixel_packer: directed byte streams, queue of expected pixels.
module tb_cam_pixel_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [1:0]  fmt;
  logic        cam_href;
  logic        cam_vsync;
  logic [7:0]  cam_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_r, out_g, out_b;
  logic        out_sof, out_eol;
  logic [9:0]  x_count;
  logic [8:0]  y_count;
  logic [15:0] frame_count;
  logic        overflow, line_err;
  logic        clr_err;

  logic [25:0] exp_q[$];
  logic [25:0] mon_e;
  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  int n_eol    = 0;
  int pops0, eol0;

`ifdef CAM_REPLICATE_LSB_EN
  localparam logic [7:0] C5_1F = 8'hFF, C6_3F = 8'hFF, C5_10 = 8'h84, C6_20 = 8'h82;
`else
  localparam logic [7:0] C5_1F = 8'hF8, C6_3F = 8'hFC, C5_10 = 8'h80, C6_20 = 8'h80;
`endif

  cam_pixel_packer dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fmt(fmt),
    .cam_href(cam_href), .cam_vsync(cam_vsync), .cam_data(cam_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_sof(out_sof), .out_eol(out_eol),
    .x_count(x_count), .y_count(y_count), .frame_count(frame_count),
    .overflow(overflow), .line_err(line_err), .clr_err(clr_err)
  );

  always #20 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // A handshake seen at the falling edge is the pop taken at the next rising edge.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      n_pops++;
      if (out_eol) n_eol++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pop: got %h expected none", {out_sof, out_eol, out_r, out_g, out_b});
      end else begin
        mon_e = exp_q.pop_front();
        check("pixel", {6'd0, out_sof, out_eol, out_r, out_g, out_b}, {6'd0, mon_e});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    cam_href = 1'b0;
    repeat (n) step();
  endtask

  task automatic send_px(input logic [7:0] hi, input logic [7:0] lo,
                         input logic [25:0] e, input bit keep);
    cam_href = 1'b1;
    cam_data = hi;
    step();
    cam_data = lo;
    if (keep) exp_q.push_back(e);
    step();
  endtask

  task automatic send_gray_line(input int n, input logic [7:0] base,
                                input bit first_sof, input int n_keep);
    logic [7:0] hi;
    for (int i = 0; i < n; i++) begin
      hi = base + 8'(i * 3);
      send_px(hi, 8'h3C ^ 8'(i), {(first_sof && i == 0), (i == 639), hi, hi, hi}, i < n_keep);
    end
    idle(2);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      step();
      k++;
    end
    step();
    check(name, exp_q.size(), 0);
  endtask

  task automatic next_frame();
    cam_href  = 1'b0;
    cam_vsync = 1'b1;
    step();
    step();
    cam_vsync = 1'b0;
    step();
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; fmt = 2'd0; cam_href = 1'b0; cam_vsync = 1'b0;
    cam_data = 8'h00; out_ready = 1'b1; clr_err = 1'b0;
    #50;
    check("rst_valid", out_valid, 0);
    check("rst_x", x_count, 0);
    check("rst_y", y_count, 0);
    check("rst_frame", frame_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_lerr", line_err, 0);
    step();
    reset_n = 1'b1;
    enable = 1'b1;
    next_frame();

    // RGB565 frame
    send_px(8'hF8, 8'h00, {1'b1, 1'b0, C5_1F, 8'h00, 8'h00}, 1'b1);
    send_px(8'h07, 8'hE0, {1'b0, 1'b0, 8'h00, C6_3F, 8'h00}, 1'b1);
    send_px(8'h00, 8'h1F, {1'b0, 1'b0, 8'h00, 8'h00, C5_1F}, 1'b1);
    send_px(8'h84, 8'h10, {1'b0, 1'b0, C5_10, C6_20, C5_10}, 1'b1);
    check("x_after_4px", x_count, 4);
    idle(1);
    check("y_after_short", y_count, 1);
    check("x_after_short", x_count, 0);
    check("lerr_short", line_err, 1);
    check("ovf_none", overflow, 0);
    pulse_clr();
    check("lerr_cleared", line_err, 0);
    wait_drain("drain_565");

    // RGB555 frame; fmt change mid-frame must not apply
    fmt = 2'd1;
    cam_vsync = 1'b1;
    step();
    check("frame_1", frame_count, 1);
    step();
    cam_vsync = 1'b0;
    step();
    fmt = 2'd2;
    send_px(8'h7C, 8'h1F, {1'b1, 1'b0, C5_1F, 8'h00, C5_1F}, 1'b1);
    send_px(8'h03, 8'hE0, {1'b0, 1'b0, 8'h00, C5_1F, 8'h00}, 1'b1);
    idle(2);
    pulse_clr();
    wait_drain("drain_555");

    // Gray frame: full line, short line, full line
    next_frame();
    check("frame_2", frame_count, 2);
    pops0 = n_pops; eol0 = n_eol;
    send_gray_line(640, 8'h80, 1'b1, 640);
    check("x_after_full", x_count, 0);
    check("y_after_full", y_count, 1);
    check("lerr_full", line_err, 0);
    wait_drain("drain_line1");
    check("pops_line1", n_pops - pops0, 640);
    check("eol_line1", n_eol - eol0, 1);
    send_gray_line(100, 8'h05, 1'b0, 100);
    check("lerr_100", line_err, 1);
    check("y_after_100", y_count, 2);
    pulse_clr();
    check("lerr_clr_100", line_err, 0);
    wait_drain("drain_line2");
    eol0 = n_eol;
    send_gray_line(640, 8'h11, 1'b0, 640);
    check("lerr_stays0", line_err, 0);
    check("y_after_line3", y_count, 3);
    wait_drain("drain_line3");
    check("eol_line3", n_eol - eol0, 1);

    // Overflow: 17 pixels into a 16-deep FIFO with no reads
    out_ready = 1'b0;
    send_gray_line(17, 8'h10, 1'b0, 16);
    check("ovf_set", overflow, 1);
    check("head_valid_hold", out_valid, 1);
    check("head_r_hold", out_r, 8'h10);
    pulse_clr();
    check("ovf_cleared", overflow, 0);
    out_ready = 1'b1;
    wait_drain("drain_ovf");

    // Push and pop on the same edge while full
    out_ready = 1'b0;
    send_gray_line(16, 8'h40, 1'b0, 16);
    check("ovf_exact16", overflow, 0);
    cam_href = 1'b1;
    cam_data = 8'hA5;
    step();
    cam_data = 8'h00;
    exp_q.push_back({1'b0, 1'b0, 8'hA5, 8'hA5, 8'hA5});
    step();
    cam_href = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    idle(2);
    check("ovf_push_pop_full", overflow, 0);
    out_ready = 1'b1;
    wait_drain("drain_full_pp");
    pulse_clr();

    // Reset mid-line with FIFO partly filled
    out_ready = 1'b0;
    send_gray_line(8, 8'h20, 1'b0, 0);
    cam_href = 1'b1;
    cam_data = 8'h77;
    step();
    #5 reset_n = 1'b0;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_x", x_count, 0);
    check("mrst_y", y_count, 0);
    check("mrst_frame", frame_count, 0);
    idle(2);
    reset_n = 1'b1;
    out_ready = 1'b1;
    pops0 = n_pops;
    send_gray_line(4, 8'h30, 1'b0, 0);
    check("no_cap_valid", out_valid, 0);
    check("no_cap_pops", n_pops - pops0, 0);
    next_frame();
    send_px(8'h80, 8'h3C, {1'b1, 1'b0, 8'h80, 8'h80, 8'h80}, 1'b1);
    idle(2);
    wait_drain("drain_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
